// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: moves whole words between a byte-wide UART interface and one
// of NUM_RAMS synchronous RAMs.
//   load (mode 0): RX bytes are packed little-endian into words and written from address 0 upward
//   dump (mode 1): words are read from address 0 upward and sent LSB byte first, paced by GAP_CLKS
// Ports:
//   clk, reset                     - clock, async active-high reset
//   start, mode, ram_sel, word_count - command, sampled only when accepted in IDLE
//   rx_valid, rx_byte              - received byte strobe
//   tx_valid, tx_ready, tx_byte    - valid/ready byte stream to the transmitter
//   mem_addr, mem_sel, mem_we, mem_wdata, mem_rdata - RAM port (1-clock read latency)
//   busy, done, timeout_err        - status
module uart_mem_bridge #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_BITS  = 8,
  parameter int NUM_RAMS   = 2,
  parameter int GAP_CLKS   = 20,
  parameter int RX_TIMEOUT = 208340,
  localparam int W        = 8 * WORD_BYTES,
  localparam int SEL_BITS = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [SEL_BITS-1:0]   ram_sel,
  input  logic [ADDR_BITS:0]    word_count,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_byte,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [NUM_RAMS-1:0]   mem_sel,
  output logic                  mem_we,
  output logic [W-1:0]          mem_wdata,
  input  logic [W-1:0]          mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int BI_W = $clog2(WORD_BYTES + 1);
  localparam int GC_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
  localparam int TO_W = $clog2(RX_TIMEOUT + 1);
  localparam int CW   = ADDR_BITS + 1;

  localparam logic [BI_W-1:0] LAST_B   = BI_W'(WORD_BYTES - 1);
  localparam logic [BI_W-1:0] ALL_B    = BI_W'(WORD_BYTES);
  localparam logic [GC_W-1:0] GAP_LAST = GC_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(RX_TIMEOUT - 1);
  localparam logic [CW-1:0]   ONE_WORD = CW'(1);

  typedef enum logic [2:0] {
    IDLE, LOAD, FETCH, WAIT_RD, SEND, GAP, FINISH
  } state_t;

  state_t          state;
  logic [BI_W-1:0] byte_idx;    // load: next byte slot; dump: bytes already sent from the word
  logic [CW-1:0]   words_left;  // includes the word currently in progress
  logic [W-1:0]    asm_q;       // load-side word assembly
  logic [W-1:0]    asm_next;
  logic [W-1:0]    shreg;       // dump-side byte shifter, next byte always in [7:0]
  logic [GC_W-1:0] gap_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            sel_ok;

  assign sel_ok = (32'(ram_sel) < NUM_RAMS);

  // Word as it will look once the byte arriving this cycle lands in its slot.
  always_comb begin
    asm_next = asm_q;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (byte_idx == BI_W'(i)) asm_next[i*8 +: 8] = rx_byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      byte_idx    <= '0;
      words_left  <= '0;
      asm_q       <= '0;
      shreg       <= '0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
      tx_valid    <= 1'b0;
      tx_byte     <= '0;
      mem_addr    <= '0;
      mem_sel     <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mem_we      <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (start && sel_ok) begin
            mem_addr   <= '0;
            byte_idx   <= '0;
            to_cnt     <= '0;
            words_left <= word_count;
            mem_sel    <= NUM_RAMS'(1) << ram_sel;
            busy       <= 1'b1;
            if (word_count == '0) state <= FINISH;
            else if (mode)        state <= FETCH;
            else                  state <= LOAD;
          end
        end

        LOAD: begin
          // mem_we high means the write happens on this edge; advance only afterwards
          // so the address seen with the strobe is the word's own address.
          if (mem_we && words_left == ONE_WORD) begin
            state <= FINISH;
          end else begin
            if (mem_we) begin
              mem_addr   <= mem_addr + 1'b1;
              words_left <= words_left - 1'b1;
            end
            if (rx_valid) begin
              to_cnt <= '0;
              asm_q  <= asm_next;
              if (byte_idx == LAST_B) begin
                byte_idx  <= '0;
                mem_wdata <= asm_next;
                mem_we    <= 1'b1;
              end else begin
                byte_idx <= byte_idx + 1'b1;
              end
            end else if (byte_idx != '0) begin
              // Silence mid-word: drop the partial word but keep the address.
              if (to_cnt == TO_LAST) begin
                byte_idx    <= '0;
                to_cnt      <= '0;
                timeout_err <= 1'b1;
              end else begin
                to_cnt <= to_cnt + 1'b1;
              end
            end
          end
        end

        FETCH: state <= WAIT_RD;

        WAIT_RD: begin
          shreg    <= mem_rdata;
          tx_byte  <= mem_rdata[7:0];
          tx_valid <= 1'b1;
          byte_idx <= '0;
          state    <= SEND;
        end

        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            shreg    <= shreg >> 8;
            byte_idx <= byte_idx + 1'b1;
            gap_cnt  <= '0;
            state    <= GAP;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (byte_idx != ALL_B) begin
              tx_byte  <= shreg[7:0];
              tx_valid <= 1'b1;
              state    <= SEND;
            end else if (words_left == ONE_WORD) begin
              state <= FINISH;
            end else begin
              mem_addr   <= mem_addr + 1'b1;
              words_left <= words_left - 1'b1;
              state      <= FETCH;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Scoreboard bench for uart_mem_bridge: directed stimulus pushes expected
// write/tx/done/timeout events; a monitor pops and compares as the DUT emits them.
module tb_uart_mem_bridge;
  localparam int WB   = 4;
  localparam int AB   = 4;
  localparam int NR   = 2;
  localparam int GAP  = 20;
  localparam int RXTO = 200;
  localparam int CW   = AB + 1;

  localparam logic [1:0] EV_WR = 2'd0, EV_TX = 2'd1, EV_DONE = 2'd2, EV_TO = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  sel;
    logic [7:0]  addr;
    logic [31:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [0:0]    ram_sel = '0;
  logic [AB:0]   word_count = '0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = '0;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic [7:0]    tx_byte;
  logic [AB-1:0] mem_addr;
  logic [NR-1:0] mem_sel;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy, done, timeout_err;

  int checks = 0;
  int failures = 0;
  int tx_seen = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  uart_mem_bridge #(
    .WORD_BYTES(WB), .ADDR_BITS(AB), .NUM_RAMS(NR), .GAP_CLKS(GAP), .RX_TIMEOUT(RXTO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .ram_sel(ram_sel),
    .word_count(word_count), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte),
    .mem_addr(mem_addr), .mem_sel(mem_sel), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  // Synchronous RAM pair with a bench-side preload port.
  logic          tb_we = 1'b0;
  logic          tb_sel = 1'b0;
  logic [AB-1:0] tb_addr = '0;
  logic [31:0]   tb_dat = '0;
  logic [31:0]   ram [NR][1<<AB];

  always @(posedge clk) begin
    if (tb_we)       ram[tb_sel][tb_addr] <= tb_dat;
    else if (mem_we) ram[mem_sel[1]][mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_sel[1]][mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic ev_t mk(input logic [1:0] k, input logic [1:0] s,
                             input logic [7:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.sel = s; e.addr = a; e.data = d;
    return e;
  endfunction

  task automatic exp_wr(input logic [1:0] s, input int a, input logic [31:0] d);
    exp_q.push_back(mk(EV_WR, s, 8'(a), d));
  endtask
  task automatic exp_tx(input logic [7:0] b);
    exp_q.push_back(mk(EV_TX, 2'b0, 8'h0, {24'h0, b}));
  endtask
  task automatic exp_done();
    exp_q.push_back(mk(EV_DONE, 2'b0, 8'h0, 32'h0));
  endtask
  task automatic exp_to();
    exp_q.push_back(mk(EV_TO, 2'b0, 8'h0, 32'h0));
  endtask

  task automatic observe(input ev_t got);
    ev_t want;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual=%h required=none", got);
    end else begin
      want = exp_q.pop_front();
      check("event", 64'(got), 64'(want));
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin : monitor
    int   cyc;
    int   hs_cyc;
    bit   have_hs;
    logic prev_tv;
    cyc = 0; hs_cyc = 0; have_hs = 0; prev_tv = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        have_hs = 0;
        prev_tv = 1'b0;
      end else begin
        if (tx_valid && !prev_tv && have_hs) begin
          checks++;
          if (cyc - hs_cyc - 1 < GAP) begin
            failures++;
            $display("FAIL tx_gap actual=%0d required>=%0d", cyc - hs_cyc - 1, GAP);
          end
        end
        if (mem_we) observe(mk(EV_WR, mem_sel, 8'(mem_addr), mem_wdata));
        if (tx_valid && tx_ready) begin
          observe(mk(EV_TX, 2'b0, 8'h0, {24'h0, tx_byte}));
          have_hs = 1;
          hs_cyc  = cyc;
          tx_seen++;
        end
        if (timeout_err) observe(mk(EV_TO, 2'b0, 8'h0, 32'h0));
        if (done) begin
          observe(mk(EV_DONE, 2'b0, 8'h0, 32'h0));
          check("busy_at_done", 64'(busy), 64'(0));
          have_hs = 0;
        end
        prev_tv = tx_valid;
      end
    end
  end

  task automatic preload(input logic s, input int a, input logic [31:0] d);
    @(posedge clk); #1;
    tb_we = 1'b1; tb_sel = s; tb_addr = AB'(a); tb_dat = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // Command pulse; afterwards the command inputs are scrambled to show they are not re-sampled.
  task automatic cmd(input logic m, input logic s, input int cnt);
    @(posedge clk); #1;
    start = 1'b1; mode = m; ram_sel = s; word_count = CW'(cnt);
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; ram_sel = ~s; word_count = '1;
  endtask

  task automatic rx(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    check(name, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctrl"}, 64'({busy, done, timeout_err, tx_valid, mem_we}), 64'(0));
    check({tag, "_data"}, 64'({mem_sel, mem_addr, tx_byte, mem_wdata}), 64'(0));
  endtask

  task automatic wait_tx_valid(input string name);
    int n;
    n = 0;
    while (!tx_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(tx_valid), 64'(1));
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] held;
    bit         stable;
    int         base, n;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset_hold");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_idle("after_release");

    // Basic load into RAM1, with a start pulse while busy that must be ignored
    exp_wr(2'b10, 0, 32'h44332211);
    exp_wr(2'b10, 1, 32'h88776655);
    exp_done();
    cmd(1'b0, 1'b1, 2);
    rx(8'h11);
    cmd(1'b1, 1'b0, 0);
    rx(8'h22); rx(8'h33); rx(8'h44);
    rx(8'h55); rx(8'h66); rx(8'h77); rx(8'h88);
    drain("load_basic", 200);

    // Basic dump of RAM0 word 0
    preload(1'b0, 0, 32'hDEADBEEF);
    tx_ready = 1'b1;
    exp_tx(8'hEF); exp_tx(8'hBE); exp_tx(8'hAD); exp_tx(8'hDE);
    exp_done();
    cmd(1'b1, 1'b0, 1);
    drain("dump_basic", 600);

    // Two-word dump with 50 clocks of backpressure on the second byte
    preload(1'b1, 0, 32'h44332211);
    preload(1'b1, 1, 32'h88776655);
    exp_tx(8'h11); exp_tx(8'h22); exp_tx(8'h33); exp_tx(8'h44);
    exp_tx(8'h55); exp_tx(8'h66); exp_tx(8'h77); exp_tx(8'h88);
    exp_done();
    base = tx_seen;
    cmd(1'b1, 1'b1, 2);
    n = 0;
    while (tx_seen < base + 1 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1 tx_ready = 1'b0;
    wait_tx_valid("bp_valid_seen");
    held = tx_byte;
    stable = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (!tx_valid || tx_byte !== held) stable = 1'b0;
    end
    check("bp_hold_stable", 64'(stable), 64'(1));
    check("bp_held_byte", 64'(held), 64'(8'h22));
    tx_ready = 1'b1;
    drain("dump_backpressure", 1200);

    // Timeout after two bytes, then a clean word lands at address 0
    exp_to();
    exp_wr(2'b01, 0, 32'h04030201);
    exp_done();
    cmd(1'b0, 1'b0, 1);
    rx(8'hAA); rx(8'hBB);
    repeat (RXTO + 20) @(posedge clk);
    rx(8'h01); rx(8'h02); rx(8'h03); rx(8'h04);
    drain("load_timeout", 200);

    // Zero-word transfers: done on the cycle after the FINISH state
    exp_done();
    cmd(1'b0, 1'b0, 0);
    check("cnt0_busy", 64'({busy, done}), 64'(2'b10));
    @(posedge clk); #1;
    check("cnt0_done", 64'({busy, done}), 64'(2'b01));
    drain("cnt0_load", 50);
    exp_done();
    cmd(1'b1, 1'b1, 0);
    drain("cnt0_dump", 50);

    // Full-range load: every address, last write at 2^AB-1, no wrap
    for (int i = 0; i < (1 << AB); i++)
      exp_wr(2'b01, i, {8'(i*4+3), 8'(i*4+2), 8'(i*4+1), 8'(i*4)});
    exp_done();
    cmd(1'b0, 1'b0, 1 << AB);
    for (int i = 0; i < (1 << AB); i++)
      for (int j = 0; j < WB; j++)
        rx(8'(i*4+j));
    drain("load_full", 400);
    check("full_last_addr", 64'(mem_addr), 64'((1 << AB) - 1));

    // Reset in the middle of a load, then a fresh load
    cmd(1'b0, 1'b1, 2);
    rx(8'h11); rx(8'h22);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_idle("rst_mid_load");
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    exp_wr(2'b10, 0, 32'h8D7C6B5A);
    exp_done();
    cmd(1'b0, 1'b1, 1);
    rx(8'h5A); rx(8'h6B); rx(8'h7C); rx(8'h8D);
    drain("load_after_rst", 200);

    // Reset while a dump byte is being offered, then a fresh load
    tx_ready = 1'b0;
    cmd(1'b1, 1'b0, 1);
    wait_tx_valid("rst_dump_send");
    reset = 1'b1;
    @(negedge clk);
    check_idle("rst_mid_dump");
    @(posedge clk); #1 reset = 1'b0;
    tx_ready = 1'b1;
    repeat (40) @(posedge clk);
    exp_wr(2'b01, 0, 32'h0DF0ADBA);
    exp_done();
    cmd(1'b0, 1'b0, 1);
    rx(8'hBA); rx(8'hAD); rx(8'hF0); rx(8'h0D);
    drain("load_after_dump_rst", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
